data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares one single-port data memory between N cores, replacing the per-core port fan-in on the data memory.
- Each core presents its 2-bit memcontrol, address and write data. The arbiter grants one core at a time using round-robin order.
- It sequences the memory access and returns read data plus a one-cycle acknowledge to the winning core.
- It sits between the Core instances and data_memory in the processor top.

Parameters:
- N_CORES, 4, number of requesting cores (2..16).
- ID_W, 4, width of grant index; must satisfy 2^ID_W >= N_CORES.
- AW, 16, address width.
- DW, 16, data width.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_ctrl  input  2*N_CORES  per-core memcontrol, core i at [2i+1:2i]: 00 idle, 01 read, 10 write, 11 reserved (treated as idle).
- req_addr  input  AW*N_CORES  per-core address, core i at [AW*i+AW-1:AW*i].
- req_wdata  input  DW*N_CORES  per-core write data, same packing as req_addr.
- ack  output  N_CORES  one-cycle completion pulse, one-hot.
- rdata  output  DW  read data; valid only when an ack bit is high.
- grant_id  output  ID_W  index of the core currently being served.
- busy  output  1  high in any state other than IDLE.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  write enable, qualified by mem_en.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, valid exactly 1 cycle after a read mem_en.

Behaviour:
- Reset values: state=IDLE; ack=0; rdata=0; grant_id=0; busy=0; mem_en=0; mem_we=0; mem_addr=0; mem_wdata=0; round-robin pointer last=N_CORES-1 (core 0 has highest priority first).
- A request is active when req_ctrl[i] is 01 or 10.
- State machine: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE, at cycle k:
  - If no request is active, stay in IDLE.
  - Otherwise, scan from (last+1) mod N_CORES upward with wrap-around; the first active core wins.
  - Register grant_id=winner, last=winner, and the winner's address, write data and op. Go to ISSUE.
- ISSUE, cycle k+1: mem_en=1; mem_we=1 for write; mem_addr/mem_wdata from the registered values. Go to WAIT.
- WAIT, cycle k+2: mem_en=0. For a read, capture mem_rdata into rdata. For a write, rdata holds its previous value. Go to DONE.
- DONE, cycle k+3: ack[grant_id]=1 for exactly this cycle. Go to IDLE.
- Latency: 3 cycles from request sampled to ack. Throughput: one access per 4 cycles.
- Requests are level-held until ack. A request still asserted in the IDLE cycle after ack counts as a new request.
- Request inputs are sampled only in IDLE. Changes to req_ctrl, req_addr or req_wdata after sampling do not affect the access in flight.
- Simultaneous requests: exactly one winner per IDLE cycle. Under continuous requests from all cores, grants rotate 0,1,..,N-1,0. No core waits more than N_CORES grants.
- Reserved code 11 never wins and never acks.
- Reset asserted in any state: the next cycle is IDLE with all outputs at reset values. The in-flight access is dropped with no ack. A write already strobed in ISSUE may have completed in memory.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, two extra outputs are present:
  - grant_count, 16 bits: increments on every ack.
  - stall_cycles, 16 bits: increments each cycle in which at least one active request exists but no ack is issued.
- Both counters saturate at 16'hFFFF and clear on reset.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan (all with N_CORES=4):
- Single read: after reset, core 2 holds req_ctrl=01, addr 16'h0010; memory returns 16'hBEEF. Required: mem_en=1 and mem_we=0 at k+1; ack=4'b0100 and rdata=16'hBEEF at k+3; grant_id=2.
- Single write: core 1 sends 10, addr 16'h0005, wdata 16'h1234. Required: mem_en=1, mem_we=1, mem_addr=16'h0005, mem_wdata=16'h1234 at k+1; ack=4'b0010 at k+3.
- Round-robin fairness: all 4 cores hold reads continuously. Required: ack order 0,1,2,3,0, spaced 4 cycles apart.
- Reserved/idle codes: core 0 sends 11, cores 1-3 send 00 for 20 cycles. Required: busy=0, mem_en=0 and ack=0 throughout.
- Reset mid-access: assert reset during WAIT of a read by core 3. Required: no ack bit goes high; next cycle busy=0 and mem_en=0. The first grant after reset goes to the lowest active index.
- With ARB_STATS_EN: cores 0 and 1 request together, one read each. Required: grant_count=2 after the second ack; stall_cycles=6 (3 per access).

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between N_CORES cores.
// Optional macro ARB_STATS_EN adds saturating grant_count / stall_cycles outputs.
module data_mem_arbiter #(
  parameter int N_CORES = 4,
  parameter int ID_W    = 4,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2*N_CORES-1:0]  req_ctrl,
  input  logic [AW*N_CORES-1:0] req_addr,
  input  logic [DW*N_CORES-1:0] req_wdata,
  output logic [N_CORES-1:0]    ack,
  output logic [DW-1:0]         rdata,
  output logic [ID_W-1:0]       grant_id,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]           grant_count,
  output logic [15:0]           stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e              state_q;
  logic [ID_W-1:0]     last_q;
  logic [ID_W-1:0]     grant_id_q;
  logic                write_q;
  logic [N_CORES-1:0]  ack_q;
  logic [DW-1:0]       rdata_q;
  logic                busy_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [AW-1:0]       mem_addr_q;
  logic [DW-1:0]       mem_wdata_q;

  logic [N_CORES-1:0]  active_s;
  logic                win_found_s;
  logic [ID_W-1:0]     win_idx_s;
  logic [AW-1:0]       win_addr_s;
  logic [DW-1:0]       win_wdata_s;
  logic                win_write_s;

  // Codes 01 and 10 are requests; 00 and the reserved 11 are ignored.
  always_comb begin
    active_s = {N_CORES{1'b0}};
    for (int i = 0; i < N_CORES; i++) begin
      active_s[i] = req_ctrl[2*i] ^ req_ctrl[2*i+1];
    end
  end

  // Round-robin pick: scan starting just after the last winner, wrapping around.
  always_comb begin
    int idx;
    idx         = 0;
    win_found_s = 1'b0;
    win_idx_s   = {ID_W{1'b0}};
    win_addr_s  = {AW{1'b0}};
    win_wdata_s = {DW{1'b0}};
    win_write_s = 1'b0;
    for (int off = 1; off <= N_CORES; off++) begin
      idx = (int'(last_q) + off) % N_CORES;
      if (!win_found_s && active_s[idx]) begin
        win_found_s = 1'b1;
        win_idx_s   = ID_W'(idx);
        win_addr_s  = req_addr[idx*AW +: AW];
        win_wdata_s = req_wdata[idx*DW +: DW];
        win_write_s = req_ctrl[2*idx+1];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Access sequencer; every output is driven straight from a register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_q      <= ID_W'(N_CORES - 1);
      grant_id_q  <= {ID_W{1'b0}};
      write_q     <= 1'b0;
      ack_q       <= {N_CORES{1'b0}};
      rdata_q     <= {DW{1'b0}};
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= {N_CORES{1'b0}};
          if (win_found_s) begin
            state_q     <= ST_ISSUE;
            grant_id_q  <= win_idx_s;
            last_q      <= win_idx_s;
            write_q     <= win_write_s;
            mem_addr_q  <= win_addr_s;
            mem_wdata_q <= win_wdata_s;
            mem_en_q    <= 1'b1;
            mem_we_q    <= win_write_s;
            busy_q      <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          // Memory answers one cycle after the strobe, i.e. during this state.
          if (!write_q) begin
            rdata_q <= mem_rdata;
          end else begin
            rdata_q <= rdata_q;
          end
          ack_q   <= {{(N_CORES-1){1'b0}}, 1'b1} << grant_id_q;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          ack_q   <= {N_CORES{1'b0}};
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          ack_q    <= {N_CORES{1'b0}};
          busy_q   <= 1'b0;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef ARB_STATS_EN
  logic [15:0] grant_count_q, grant_count_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  // Saturating counters: acks issued, and cycles with pending work but no ack.
  always_comb begin
    grant_count_d  = grant_count_q;
    stall_cycles_d = stall_cycles_q;
    if ((|ack_q) && (grant_count_q != 16'hFFFF)) begin
      grant_count_d = grant_count_q + 16'd1;
    end else begin
      grant_count_d = grant_count_q;
    end
    if ((|active_s) && !(|ack_q) && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_count_q  <= 16'd0;
      stall_cycles_q <= 16'd0;
    end else begin
      grant_count_q  <= grant_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign grant_count  = grant_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter (N_CORES=4); stats checks run when ARB_STATS_EN is defined.
module tb_data_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  req_ctrl = 8'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic [3:0]  ack;
  logic [15:0] rdata;
  logic [3:0]  grant_id;
  logic        busy, mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'd0;
`ifdef ARB_STATS_EN
  logic [15:0] grant_count, stall_cycles;
`endif

  data_mem_arbiter #(.N_CORES(4), .ID_W(4), .AW(16), .DW(16)) dut (
    .clock(clock), .reset(reset),
    .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .rdata(rdata), .grant_id(grant_id), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .grant_count(grant_count), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory model with fixed contents, one-cycle read latency.
  function automatic logic [15:0] mem_val(input logic [15:0] a);
    case (a)
      16'h0010: mem_val = 16'hBEEF;
      16'h0020: mem_val = 16'hA000;
      16'h0021: mem_val = 16'hA001;
      16'h0022: mem_val = 16'hA002;
      16'h0023: mem_val = 16'hA003;
      default:  mem_val = 16'hDEAD;
    endcase
  endfunction

  always @(posedge clock) begin
    if (mem_en && !mem_we) mem_rdata <= mem_val(mem_addr);
  end

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct {
    logic [3:0]  ack;
    logic [15:0] rdata;
    logic [3:0]  gid;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  bit mon_en = 1'b0;

  // Monitor: every ack pulse is matched against the oldest expected response.
  always @(negedge clock) begin
    if (mon_en && ack !== 4'b0000) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_ack: got %b expected none (cycle %0d)", ack, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack", 32'(ack), 32'(e.ack));
        chk("rdata", 32'(rdata), 32'(e.rdata));
        chk("grant_id", 32'(grant_id), 32'(e.gid));
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int core, input logic [1:0] c, input logic [15:0] a, input logic [15:0] d);
    req_ctrl[2*core +: 2]   = c;
    req_addr[16*core +: 16] = a;
    req_wdata[16*core +: 16] = d;
  endtask

  task automatic push(input logic [3:0] a, input logic [15:0] r, input logic [3:0] g, input int c);
    exp_t e;
    e.ack = a; e.rdata = r; e.gid = g; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_ctrl = 8'd0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy_en_we", {29'd0, busy, mem_en, mem_we}, 32'd0);
    chk("rst_mem_addr_wdata", {mem_addr, mem_wdata}, 32'd0);
`ifdef ARB_STATS_EN
    chk("rst_stats", {grant_count, stall_cycles}, 32'd0);
`endif
    mon_en = 1'b1;
  endtask

  initial begin
    int c0;
    do_reset();

    // Single read by core 2.
    tick();
    set_req(2, 2'b01, 16'h0010, 16'h0000);
    c0 = cyc;
    push(4'b0100, 16'hBEEF, 4'd2, c0 + 3);
    @(negedge clock);
    chk("rd_idle_mem_en", 32'(mem_en), 32'd0);
    @(negedge clock);
    chk("rd_issue_en_we", {30'd0, mem_en, mem_we}, 32'b10);
    chk("rd_issue_addr", 32'(mem_addr), 32'h0010);
    chk("rd_issue_busy_gid", {27'd0, busy, grant_id}, {27'd0, 1'b1, 4'd2});
    @(negedge clock);
    chk("rd_wait_mem_en", 32'(mem_en), 32'd0);
    repeat (2) tick();
    req_ctrl = 8'd0;

    // Single write by core 1; rdata must keep the previous read value.
    tick();
    set_req(1, 2'b10, 16'h0005, 16'h1234);
    c0 = cyc;
    push(4'b0010, 16'hBEEF, 4'd1, c0 + 3);
    @(negedge clock);
    @(negedge clock);
    chk("wr_issue_en_we", {30'd0, mem_en, mem_we}, 32'b11);
    chk("wr_issue_addr", 32'(mem_addr), 32'h0005);
    chk("wr_issue_wdata", 32'(mem_wdata), 32'h1234);
    repeat (3) tick();
    req_ctrl = 8'd0;

    // Round-robin with all four cores reading continuously.
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) set_req(i, 2'b01, 16'h0020 + 16'(i), 16'h0000);
    c0 = cyc;
    push(4'b0001, 16'hA000, 4'd0, c0 + 3);
    push(4'b0010, 16'hA001, 4'd1, c0 + 7);
    push(4'b0100, 16'hA002, 4'd2, c0 + 11);
    push(4'b1000, 16'hA003, 4'd3, c0 + 15);
    push(4'b0001, 16'hA000, 4'd0, c0 + 19);
    repeat (20) tick();
    req_ctrl = 8'd0;
    repeat (4) tick();

    // Reserved code from core 0, idle elsewhere: nothing may start.
    set_req(0, 2'b11, 16'h0020, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("reserved_quiet", {29'd0, busy, mem_en, |ack}, 32'd0);
    end
    tick();
    req_ctrl = 8'd0;

    // Reset during WAIT of a core 3 read: access dropped, then core 1 wins.
    do_reset();
    tick();
    set_req(3, 2'b01, 16'h0023, 16'h0000);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(1, 2'b01, 16'h0021, 16'h0000);
    c0 = cyc;
    push(4'b0010, 16'hA001, 4'd1, c0 + 3);
    @(negedge clock);
    chk("midrst_quiet", {28'd0, |ack, busy, mem_en, mem_we}, 32'd0);
    @(negedge clock);
    chk("midrst_first_grant", 32'(grant_id), 32'd1);
    chk("midrst_first_addr", 32'(mem_addr), 32'h0021);
    repeat (3) tick();
    req_ctrl = 8'd0;
    repeat (4) tick();

`ifdef ARB_STATS_EN
    // Two simultaneous single reads: 2 grants, 3 stall cycles each.
    do_reset();
    tick();
    set_req(0, 2'b01, 16'h0020, 16'h0000);
    set_req(1, 2'b01, 16'h0021, 16'h0000);
    c0 = cyc;
    push(4'b0001, 16'hA000, 4'd0, c0 + 3);
    push(4'b0010, 16'hA001, 4'd1, c0 + 7);
    repeat (4) tick();
    set_req(0, 2'b00, 16'h0000, 16'h0000);
    repeat (4) tick();
    req_ctrl = 8'd0;
    @(negedge clock);
    chk("stats_grant_count", 32'(grant_count), 32'd2);
    chk("stats_stall_cycles", 32'(stall_cycles), 32'd6);
`endif

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 40 && sb.size() > 0; t++) @(posedge clock);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      $display("FAIL missing_ack: got none expected ack %b at cycle %0d", e.ack, e.cyc);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
